// File: rtl/jtvigil_romarb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : jtvigil_romarb                                               |
// | Description : Shares one 16-bit SDRAM read port between the main CPU, the  |
// |               sound CPU and the scroll-graphics fetcher. Each requester    |
// |               has a one-word cache. A starvation counter guarantees the    |
// |               sound CPU a grant after three pass-overs.                    |
// | Ports       : clk/rst_n        clock, async active-low reset               |
// |               dwnld            ROM download: flush caches, block grants    |
// |               main_*           main CPU byte port (18-bit addr, 8-bit data)|
// |               snd_*            sound CPU byte port (15-bit addr, 8-bit)    |
// |               gfx_*            gfx word port (17-bit addr, 16-bit data)    |
// |               sdram_*          request/ack/data-strobe SDRAM read port     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module jtvigil_romarb #(
   parameter logic [21:0] MAIN_OFFSET = 22'h00000,
   parameter logic [21:0] SND_OFFSET  = 22'h10000,
   parameter logic [21:0] GFX_OFFSET  = 22'h20000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dwnld,
   input  logic        main_cs,
   input  logic [17:0] main_addr,
   output logic [7:0]  main_dout,
   output logic        main_ok,
   input  logic        snd_cs,
   input  logic [14:0] snd_addr,
   output logic [7:0]  snd_dout,
   output logic        snd_ok,
   input  logic        gfx_cs,
   input  logic [16:0] gfx_addr,
   output logic [15:0] gfx_dout,
   output logic        gfx_ok,
   output logic        sdram_req,
   output logic [21:0] sdram_addr,
   input  logic        sdram_ack,
   input  logic        sdram_dst,
   input  logic [15:0] sdram_data
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WACK = 2'd1;
   localparam logic [1:0] ST_WDST = 2'd2;

   localparam logic [1:0] OWN_MAIN = 2'd0;
   localparam logic [1:0] OWN_SND  = 2'd1;
   localparam logic [1:0] OWN_GFX  = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [1:0]  owner_q, owner_d;
   logic [16:0] lat_addr_q, lat_addr_d;
   logic        req_q, req_d;
   logic [21:0] addr_q, addr_d;
   logic [1:0]  snd_wait_q, snd_wait_d;

   logic [16:0] main_tag_q, gfx_tag_q;
   logic [13:0] snd_tag_q;
   logic [15:0] main_data_q, snd_data_q, gfx_data_q;
   logic        main_valid_q, snd_valid_q, gfx_valid_q;

   logic [16:0] main_word;
   logic [13:0] snd_word;
   logic        main_hit, snd_hit, gfx_hit;
   logic        main_miss, snd_miss, gfx_miss;
   logic        gnt_main, gnt_snd, gnt_gfx;
   logic        cache_wr;

   assign main_word = main_addr[17:1];
   assign snd_word  = snd_addr[14:1];

   assign main_hit  = main_cs && main_valid_q && (main_tag_q == main_word);
   assign snd_hit   = snd_cs  && snd_valid_q  && (snd_tag_q  == snd_word);
   assign gfx_hit   = gfx_cs  && gfx_valid_q  && (gfx_tag_q  == gfx_addr);
   assign main_miss = main_cs && !main_hit;
   assign snd_miss  = snd_cs  && !snd_hit;
   assign gfx_miss  = gfx_cs  && !gfx_hit;

   assign main_ok   = main_hit;
   assign snd_ok    = snd_hit;
   assign gfx_ok    = gfx_hit;
   assign main_dout = main_addr[0] ? main_data_q[15:8] : main_data_q[7:0];
   assign snd_dout  = snd_addr[0]  ? snd_data_q[15:8]  : snd_data_q[7:0];
   assign gfx_dout  = gfx_data_q;

   assign sdram_req  = req_q;
   assign sdram_addr = addr_q;

   // Data strobes outside WAIT_DST are stale or illegal and must not touch the caches.
   assign cache_wr = (state_q == ST_WDST) && sdram_dst;

   // Grant selection: gfx > main > snd, except that a sound CPU passed over
   // three times in a row takes the next slot.
   always_comb begin
      gnt_main = 1'b0;
      gnt_snd  = 1'b0;
      gnt_gfx  = 1'b0;
      if (state_q == ST_IDLE && !dwnld) begin
         if (snd_miss && snd_wait_q == 2'd3) gnt_snd  = 1'b1;
         else if (gfx_miss)                  gnt_gfx  = 1'b1;
         else if (main_miss)                 gnt_main = 1'b1;
         else if (snd_miss)                  gnt_snd  = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      lat_addr_d = lat_addr_q;
      req_d      = req_q;
      addr_d     = addr_q;
      snd_wait_d = snd_wait_q;

      if (!snd_cs || gnt_snd) begin
         snd_wait_d = 2'd0;
      end else if ((gnt_gfx || gnt_main) && snd_miss && snd_wait_q != 2'd3) begin
         snd_wait_d = snd_wait_q + 2'd1;
      end

      case (state_q)
         ST_IDLE: begin
            if (gnt_gfx) begin
               owner_d    = OWN_GFX;
               lat_addr_d = gfx_addr;
               addr_d     = GFX_OFFSET + {5'd0, gfx_addr};
            end else if (gnt_main) begin
               owner_d    = OWN_MAIN;
               lat_addr_d = main_word;
               addr_d     = MAIN_OFFSET + {5'd0, main_word};
            end else if (gnt_snd) begin
               owner_d    = OWN_SND;
               lat_addr_d = {3'd0, snd_word};
               addr_d     = SND_OFFSET + {8'd0, snd_word};
            end
            if (gnt_gfx || gnt_main || gnt_snd) begin
               req_d   = 1'b1;
               state_d = ST_WACK;
            end
         end
         ST_WACK: begin
            if (sdram_ack) begin
               req_d   = 1'b0;
               state_d = ST_WDST;
            end
         end
         ST_WDST: begin
            if (sdram_dst) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         owner_q      <= OWN_MAIN;
         lat_addr_q   <= 17'd0;
         req_q        <= 1'b0;
         addr_q       <= 22'd0;
         snd_wait_q   <= 2'd0;
         main_tag_q   <= 17'd0;
         snd_tag_q    <= 14'd0;
         gfx_tag_q    <= 17'd0;
         main_data_q  <= 16'd0;
         snd_data_q   <= 16'd0;
         gfx_data_q   <= 16'd0;
         main_valid_q <= 1'b0;
         snd_valid_q  <= 1'b0;
         gfx_valid_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         lat_addr_q <= lat_addr_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         snd_wait_q <= snd_wait_d;

         // Data is stored regardless of whether the owner still wants it;
         // the tag compare keeps ok low if its address moved on.
         if (cache_wr) begin
            case (owner_q)
               OWN_MAIN: begin
                  main_tag_q  <= lat_addr_q;
                  main_data_q <= sdram_data;
               end
               OWN_SND: begin
                  snd_tag_q  <= lat_addr_q[13:0];
                  snd_data_q <= sdram_data;
               end
               default: begin
                  gfx_tag_q  <= lat_addr_q;
                  gfx_data_q <= sdram_data;
               end
            endcase
         end

         // A download rewrites the ROM, so nothing fetched during it can be trusted.
         if (dwnld) begin
            main_valid_q <= 1'b0;
            snd_valid_q  <= 1'b0;
            gfx_valid_q  <= 1'b0;
         end else if (cache_wr) begin
            case (owner_q)
               OWN_MAIN: main_valid_q <= 1'b1;
               OWN_SND:  snd_valid_q  <= 1'b1;
               default:  gfx_valid_q  <= 1'b1;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_jtvigil_romarb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_jtvigil_romarb                                            |
// | Description : Self-checking bench for jtvigil_romarb. Expected SDRAM       |
// |               addresses are queued when requests are provoked and popped   |
// |               as the arbiter issues them; cache outputs are checked        |
// |               against bench constants.                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_jtvigil_romarb;

   localparam logic [21:0] GFX_OFF = 22'h3FFFF0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        dwnld;
   logic        main_cs, snd_cs, gfx_cs;
   logic [17:0] main_addr;
   logic [14:0] snd_addr;
   logic [16:0] gfx_addr;
   logic [7:0]  main_dout, snd_dout;
   logic [15:0] gfx_dout;
   logic        main_ok, snd_ok, gfx_ok;
   logic        sdram_req, sdram_ack, sdram_dst;
   logic [21:0] sdram_addr;
   logic [15:0] sdram_data;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [21:0] exp_q[$];

   always #5 clk = ~clk;

   jtvigil_romarb #(
      .MAIN_OFFSET(22'h00000),
      .SND_OFFSET (22'h10000),
      .GFX_OFFSET (GFX_OFF)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .dwnld     (dwnld),
      .main_cs   (main_cs),
      .main_addr (main_addr),
      .main_dout (main_dout),
      .main_ok   (main_ok),
      .snd_cs    (snd_cs),
      .snd_addr  (snd_addr),
      .snd_dout  (snd_dout),
      .snd_ok    (snd_ok),
      .gfx_cs    (gfx_cs),
      .gfx_addr  (gfx_addr),
      .gfx_dout  (gfx_dout),
      .gfx_ok    (gfx_ok),
      .sdram_req (sdram_req),
      .sdram_addr(sdram_addr),
      .sdram_ack (sdram_ack),
      .sdram_dst (sdram_dst),
      .sdram_data(sdram_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for a request, then pop and compare its address.
   task automatic get_req(input string tag);
      int k;
      k = 0;
      while (!sdram_req && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!sdram_req) begin
         chk({tag, "_req"}, 32'(sdram_req), 1);
      end else if (exp_q.size() == 0) begin
         chk({tag, "_sb"}, 32'(exp_q.size()), 1);
      end else begin
         chk(tag, 32'(sdram_addr), 32'(exp_q.pop_front()));
      end
   endtask

   // Acknowledge the pending request and return data; dwnld is applied in WAIT_DST.
   task automatic finish(input logic [15:0] d, input logic dw);
      @(negedge clk);
      sdram_ack = 1'b1;
      @(negedge clk);
      sdram_ack = 1'b0;
      chk("req_drop", 32'(sdram_req), 0);
      dwnld = dw;
      @(negedge clk);
      sdram_dst  = 1'b1;
      sdram_data = d;
      @(negedge clk);
      sdram_dst  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; dwnld = 1'b0;
      main_cs = 1'b0; snd_cs = 1'b0; gfx_cs = 1'b0;
      main_addr = '0; snd_addr = '0; gfx_addr = '0;
      sdram_ack = 1'b0; sdram_dst = 1'b0; sdram_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_req",  32'(sdram_req), 0);
      chk("rst_addr", 32'(sdram_addr), 0);
      chk("rst_oks",  32'({main_ok, snd_ok, gfx_ok}), 0);
      chk("rst_dout", 32'({main_dout, snd_dout, gfx_dout}), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Main miss, then a hit on the other byte of the same word
      main_cs = 1'b1; main_addr = 18'h00101;
      exp_q.push_back(22'h00080);
      #1 chk("main_miss_ok", 32'(main_ok), 0);
      get_req("main_addr");
      finish(16'hBEEF, 1'b0);
      chk("main_ok",   32'(main_ok), 1);
      chk("main_dout", 32'(main_dout), 32'h0BE);
      main_addr = 18'h00100;
      #1 chk("main_ok_lo",   32'(main_ok), 1);
      chk("main_dout_lo", 32'(main_dout), 32'h0EF);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("main_hit_noreq", 32'(sdram_req), 0);
      end

      // Priority: gfx, main, snd miss together; gfx address wraps
      gfx_cs = 1'b1; gfx_addr = 17'h00020;
      main_addr = 18'h00456;
      snd_cs = 1'b1; snd_addr = 15'h1234;
      exp_q.push_back(22'h000010);
      exp_q.push_back(22'h00022B);
      exp_q.push_back(22'h01091A);
      get_req("pri_gfx");
      chk("pri_wait1", 32'(dut.snd_wait_q), 1);
      finish(16'hC0DE, 1'b0);
      get_req("pri_main");
      chk("pri_wait2", 32'(dut.snd_wait_q), 2);
      finish(16'h1234, 1'b0);
      get_req("pri_snd");
      chk("pri_wait0", 32'(dut.snd_wait_q), 0);
      finish(16'h5678, 1'b0);
      chk("pri_gfx_data",  32'({gfx_ok, gfx_dout}), 32'h1C0DE);
      chk("pri_main_data", 32'({main_ok, main_dout}), 32'h134);
      chk("pri_snd_data",  32'({snd_ok, snd_dout}), 32'h178);

      // Starvation: gfx keeps missing; snd gets the fourth slot
      gfx_addr = 17'h00100; main_addr = 18'h00800; snd_addr = 15'h0202;
      exp_q.push_back(22'h0000F0);
      exp_q.push_back(22'h0000F1);
      exp_q.push_back(22'h0000F2);
      exp_q.push_back(22'h010101);
      exp_q.push_back(22'h0000F3);
      exp_q.push_back(22'h000400);
      for (int i = 0; i < 3; i++) begin
         get_req("stv_gfx");
         chk("stv_wait", 32'(dut.snd_wait_q), i + 1);
         finish(16'h0A00 + 16'(i), 1'b0);
         gfx_addr = gfx_addr + 17'd1;
      end
      get_req("stv_snd");
      chk("stv_wait_clr", 32'(dut.snd_wait_q), 0);
      finish(16'hA55A, 1'b0);
      chk("stv_snd_data", 32'({snd_ok, snd_dout}), 32'h15A);
      get_req("stv_gfx4");
      finish(16'h0A03, 1'b0);
      get_req("stv_main");
      finish(16'h7E81, 1'b0);
      chk("stv_all_ok", 32'({main_ok, snd_ok, gfx_ok}), 32'h7);

      // Download asserted while waiting for data
      gfx_addr = 17'h00055;
      exp_q.push_back(22'h000045);
      get_req("dw_gfx");
      finish(16'h4444, 1'b1);
      chk("dw_oks", 32'({main_ok, snd_ok, gfx_ok}), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("dw_noreq", 32'(sdram_req), 0);
      end
      dwnld = 1'b0;
      exp_q.push_back(22'h000045);
      exp_q.push_back(22'h000400);
      exp_q.push_back(22'h010101);
      #1 chk("dw_oks_after", 32'({main_ok, snd_ok, gfx_ok}), 0);
      get_req("dw_re_gfx");
      finish(16'h4545, 1'b0);
      get_req("dw_re_main");
      finish(16'h7E81, 1'b0);
      get_req("dw_re_snd");
      finish(16'hA55A, 1'b0);
      chk("dw_refetch", 32'({main_ok, snd_ok, gfx_ok, gfx_dout}), 32'h74545);

      // Reset during WAIT_ACK
      main_addr = 18'h01000;
      exp_q.push_back(22'h000800);
      get_req("rst_main");
      @(negedge clk);
      rst_n = 1'b0;
      #1 chk("arst_req", 32'(sdram_req), 0);
      chk("arst_oks",   32'({main_ok, snd_ok, gfx_ok}), 0);
      chk("arst_state", 32'(dut.state_q), 0);
      main_cs = 1'b0; snd_cs = 1'b0; gfx_cs = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      sdram_dst = 1'b1; sdram_data = 16'hFFFF;
      @(negedge clk);
      sdram_dst = 1'b0;
      chk("stray_noreq", 32'(sdram_req), 0);
      main_cs = 1'b1; main_addr = 18'h00000;
      gfx_cs = 1'b1; gfx_addr = 17'h00000;
      #1 chk("stray_main", 32'({main_ok, main_dout}), 0);
      chk("stray_gfx", 32'({gfx_ok, gfx_dout}), 0);
      main_cs = 1'b0; gfx_cs = 1'b0;
      @(negedge clk);

      chk("sb_empty", 32'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
